jcnt_slot_tx: RTL and testbench

//  Transmit side of the Johnson-phase sampled data link. Owns the Johnson counter
//  (jcnt_out) and a small word FIFO, and drives data_out to the downstream sampling

---
 rtl/jcnt_pkg.sv | 47 ++++
 rtl/jcnt_slot_tx_if.sv | 26 ++
 rtl/jslot_fifo.sv | 54 +++++
 rtl/jcnt_slot_tx.sv | 96 +++++++++
 tb/tb_jcnt_slot_tx.sv | 127 ++++++++++++
 5 files changed

// File: rtl/jcnt_pkg.sv
// Shared Johnson-code helpers for the sampled data link.
// Codes are carried in a JW_MAX-bit container; w selects the active low bits.
package jcnt_pkg;

  localparam int unsigned JW_MAX = 32;

  typedef logic [JW_MAX-1:0] jcode_t;

  // Mask with the low n bits set.
  function automatic jcode_t ones(input int unsigned n);
    if (n >= JW_MAX) return '1;
    return jcode_t'((64'd1 << n) - 64'd1);
  endfunction

  // Update phase A: upper half ones, lower half zeros.
  function automatic jcode_t upd_a_code(input int unsigned w);
    return ones(w) & ~ones(w / 2);
  endfunction

  // Update phase B: upper half zeros, lower half ones.
  function automatic jcode_t upd_b_code(input int unsigned w);
    return ones(w / 2);
  endfunction

  function automatic jcode_t cap_code0(input int unsigned w);
    return ones(w) & jcode_t'(0);
  endfunction

  function automatic jcode_t cap_code1(input int unsigned w);
    return ones(w);
  endfunction

  // Legal Johnson states have at most one boundary between adjacent bits.
  function automatic logic is_johnson(input int unsigned w, input jcode_t code);
    jcode_t t;
    t = (code ^ (code >> 1)) & ones(w - 1);
    return (t & (t - jcode_t'(1))) == '0;
  endfunction

  // Shift right, feeding the inverted LSB into the MSB.
  function automatic jcode_t jcnt_next(input int unsigned w, input jcode_t code);
    jcode_t top;
    top = (code[0] ? jcode_t'(0) : jcode_t'(1)) << (w - 1);
    return ((code >> 1) & ones(w - 1)) | top;
  endfunction

endpackage

// File: rtl/jcnt_slot_tx_if.sv
// Transmit-side link bundle: word input handshake plus the latch-facing outputs.
//   in_data/in_valid/in_ready : word handshake into the transmitter
//   jcnt_out/data_out         : Johnson phase and data to the receiver latch
//   slot_load/underrun/code_err : single-cycle status pulses
interface jcnt_slot_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] jcnt_out;
  logic [WIDTH-1:0] data_out;
  logic             slot_load;
  logic             underrun;
  logic             code_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, jcnt_out, data_out, slot_load, underrun, code_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, jcnt_out, data_out, slot_load, underrun, code_err
  );
endinterface

// File: rtl/jslot_fifo.sv
// DEPTH x WIDTH synchronous word FIFO, no fall-through.
//   push/push_data : write at the rising edge (caller guarantees !full)
//   pop/pop_data   : pop_data shows the head; pop removes it (caller guarantees !empty)
//   full/empty     : derived from the registered occupancy
module jslot_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

  // Storage needs no reset: it is only read while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/jcnt_slot_tx.sv
// Johnson-phase sampled link transmitter. Runs the Johnson counter, queues words
// and updates data_out only when leaving the mid-period update phases, so each
// word is stable across exactly one capture phase (all-0 or all-1).
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of jcnt_slot_tx_if (handshake in, latch outputs out)
module jcnt_slot_tx
  import jcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  jcnt_slot_tx_if.slave      bus
);
  localparam logic [WIDTH-1:0] UPD_A = WIDTH'(upd_a_code(WIDTH));
  localparam logic [WIDTH-1:0] UPD_B = WIDTH'(upd_b_code(WIDTH));

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt;
  logic [WIDTH-1:0] data_q, data_d;
  logic             slot_load_q, slot_load_d;
  logic             underrun_q, underrun_d;
  logic             code_err_q, code_err_d;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic             push_c, pop_c;

  // Decode view of the counter, kept separate from the register itself.
  assign cnt = cnt_q;

  assign push_c = bus.in_valid && !fifo_full;

  jslot_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (bus.in_data),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Counter advance, illegal-state recovery and slot decision.
  always_comb begin
    cnt_d       = '0;
    data_d      = data_q;
    slot_load_d = 1'b0;
    underrun_d  = 1'b0;
    code_err_d  = 1'b0;
    pop_c       = 1'b0;
    if (!is_johnson(WIDTH, jcode_t'(cnt))) begin
      // Recovery edge: restart at phase 0 and skip the slot decision.
      code_err_d = 1'b1;
    end else begin
      cnt_d = WIDTH'(jcnt_next(WIDTH, jcode_t'(cnt)));
      if (cnt == UPD_A || cnt == UPD_B) begin
        if (!fifo_empty) begin
          data_d      = fifo_head;
          pop_c       = 1'b1;
          slot_load_d = 1'b1;
        end else begin
          underrun_d  = 1'b1;
        end
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      data_q      <= '0;
      slot_load_q <= 1'b0;
      underrun_q  <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      slot_load_q <= slot_load_d;
      underrun_q  <= underrun_d;
      code_err_q  <= code_err_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.jcnt_out  = cnt_q;
  assign bus.data_out  = data_q;
  assign bus.slot_load = slot_load_q;
  assign bus.underrun  = underrun_q;
  assign bus.code_err  = code_err_q;
endmodule

// File: tb/tb_jcnt_slot_tx.sv
// Randomized bench for jcnt_slot_tx against a phase-index / queue reference model.
module tb_jcnt_slot_tx;
  localparam int W = 4;
  localparam int D = 2;
  localparam int N_CYC = 500;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jcnt_slot_tx_if #(.WIDTH(W)) bus ();

  jcnt_slot_tx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: phase index 0..2W-1 and a word queue.
  int m_phase;
  int m_q[$];
  int m_data;
  bit m_slot, m_und, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Johnson code of phase p, straight from the phase description.
  function automatic int code_of(input int p);
    int k;
    if (p <= W) return ((1 << p) - 1) << (W - p);
    k = p - W;
    return (1 << (W - k)) - 1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_data = 0;
    m_slot = 0;
    m_und  = 0;
    m_err  = 0;
  endtask

  task automatic model_edge(input bit forced, input bit valid, input int din);
    bit push;
    push   = valid && (m_q.size() < D);
    m_slot = 0;
    m_und  = 0;
    m_err  = 0;
    if (forced) begin
      m_err   = 1;
      m_phase = 0;
    end else begin
      if (m_phase == W / 2 || m_phase == 3 * W / 2) begin
        if (m_q.size() > 0) begin
          m_data = m_q.pop_front();
          m_slot = 1;
        end else begin
          m_und = 1;
        end
      end
      m_phase = (m_phase + 1) % (2 * W);
    end
    if (push) m_q.push_back(din);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".jcnt"},     32'(bus.jcnt_out),  32'(code_of(m_phase)));
    check({tag, ".data"},     32'(bus.data_out),  32'(m_data));
    check({tag, ".slot"},     32'(bus.slot_load), 32'(m_slot));
    check({tag, ".underrun"}, 32'(bus.underrun),  32'(m_und));
    check({tag, ".code_err"}, 32'(bus.code_err),  32'(m_err));
    check({tag, ".ready"},    32'(bus.in_ready),  32'(m_q.size() < D));
  endtask

  initial begin
    int  dens;
    bit  forced;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      dens = (cyc < 100) ? 15 : (cyc < 250) ? 90 : 50;
      bus.in_valid = ($urandom % 100) < dens;
      bus.in_data  = W'($urandom);
      forced = (cyc == 150 || cyc == 400);
      if (forced) force dut.cnt = 4'b1010;
      @(posedge clk);
      model_edge(forced, bus.in_valid, int'(bus.in_data));
      #1;
      if (forced) release dut.cnt;
      @(negedge clk);
      check_all(forced ? "illegal" : "run");

      if (cyc == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        @(posedge clk);
        @(negedge clk);
        check_all("midreset_hold");
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
